pc_sequencer: RTL

- Program-counter and fetch/execute controller for the single-cycle 16-bit datapath.
- Drives the instruction-memory address and holds the equality flag written by cmp.
- Resolves jmp/je/jne and holds the core on halt until the board push button is pressed.
- Also provides a single-step mode for VGA debug viewing.

---
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute controller: one instruction per cycle in RUN,
// halt/single-step pauses released by a debounced push button, sticky fault on illegal address.
module pc_sequencer #(
  parameter int ADDR_W          = 12,
  parameter int INST_W          = 16,
  parameter int MEM_DEPTH       = 64,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button,
  input  logic              step_mode,
  input  logic [INST_W-1:0] instr,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_en,
  output logic              eq_flag,
  output logic              halted,
  output logic              fault
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH   = (ADDR_W + 1)'(MEM_DEPTH);

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_JNE  = 4'b0011;
  localparam logic [3:0] OP_JE   = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b1000;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP_WAIT, S_FAULT} state_t;

  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n, w_next_pc, w_pc_inc, w_target;
  logic              r_eq, w_eq_n;
  logic              r_halted, r_fault, w_exec;
  logic              r_sync1, r_sync2, r_db_level, r_db_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_press, w_next_bad, w_inc_bad;
  logic [3:0]        w_opcode;
  logic              w_unused_instr;

  assign w_opcode       = instr[INST_W-1:INST_W-4];
  assign w_target       = {{(ADDR_W-6){1'b0}}, instr[5:0]};
  assign w_unused_instr = ^instr[INST_W-5:6];
  assign w_pc_inc       = r_pc + ADDR_W'(1);
  assign w_press        = r_db_level & ~r_db_prev;

  // Branches resolve against the flag as it stood before this edge.
  always_comb begin
    w_next_pc = w_pc_inc;
    case (w_opcode)
      OP_JMP:  w_next_pc = w_target;
      OP_JE:   if (r_eq)  w_next_pc = w_target;
      OP_JNE:  if (!r_eq) w_next_pc = w_target;
      default: w_next_pc = w_pc_inc;
    endcase
  end

  assign w_next_bad = ({1'b0, w_next_pc} >= DEPTH);
  assign w_inc_bad  = ({1'b0, w_pc_inc} >= DEPTH);

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_eq_n    = r_eq;
    w_exec    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_exec = (w_opcode != OP_HALT);
        if (w_opcode == OP_HALT) begin
          w_state_n = S_HALT;
        end else begin
          if (w_opcode == OP_CMP) w_eq_n = alu_zero;
          if (w_next_bad) begin
            w_state_n = S_FAULT;
          end else begin
            w_pc_n    = w_next_pc;
            w_state_n = step_mode ? S_STEP_WAIT : S_RUN;
          end
        end
      end
      S_HALT: begin
        if (w_press) begin
          if (w_inc_bad) begin
            w_state_n = S_FAULT;
          end else begin
            w_pc_n    = w_pc_inc;
            w_state_n = S_RUN;
          end
        end
      end
      S_STEP_WAIT: if (w_press) w_state_n = S_RUN;
      default:     w_state_n = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_pc     <= '0;
      r_eq     <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_eq     <= w_eq_n;
      r_halted <= (w_state_n == S_HALT) || (w_state_n == S_STEP_WAIT);
      r_fault  <= (w_state_n == S_FAULT);
    end
  end

  // Two-flop synchronizer, then a level only accepted after enough stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1   <= button;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_db_level <= r_sync2;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pc      = r_pc;
  assign exec_en = w_exec;
  assign eq_flag = r_eq;
  assign halted  = r_halted;
  assign fault   = r_fault;

endmodule
